// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for the per-layer control FSMs.
//   seq_state_t : layer_sequencer state encoding
//   out_width   : width of a layer output / result vector (ROWS * 2*DATAWIDTH)
//   bias_width  : width of a bias delta vector (ROWS * 2*DATAWIDTH)
//   idx_width   : counter/index width for a range of n values, at least 1 bit
package nn_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      I_CLR,
      I_FIRE,
      I_WAIT,
      I_HOLD,
      T_LOAD,
      T_PULSE,
      T_GAP
   } seq_state_t;

   function automatic int unsigned out_width(input int unsigned rows, input int unsigned dw);
      return rows * 2 * dw;
   endfunction

   function automatic int unsigned bias_width(input int unsigned rows, input int unsigned dw);
      return rows * 2 * dw;
   endfunction

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/layer_sequencer.sv
// Control FSM for one fully connected layer instance.
// Inference: clear layer values, pulse en, wait for done (bounded by TIMEOUT),
// hold the captured output until the ready/valid consumer takes it.
// Training: accept one weight row per handshake, pulse train_en per row with a
// mandatory low gap; bias deltas are only driven on the row-0 pulse.
//
// Ports
//   clk, rst_overall_n              clock, synchronous active-low reset
//   inf_req / inf_busy              inference request / busy
//   res_valid, res_ready, res_data  result holding register handshake
//   trn_req, trn_done               training start / completion pulse
//   w_valid, w_ready, w_data        weight row handshake
//   b_data                          bias deltas, sampled with row 0
//   timeout_err                     sticky done-timeout flag
//   lyr_*                           connections to the layer instance
//
// state   | meaning
// --------+----------------------------------------------------
// IDLE    | waiting for inf_req (priority) or trn_req
// I_CLR   | lyr_rst_vals high for one cycle
// I_FIRE  | lyr_en high for one cycle, timeout count starts at 0
// I_WAIT  | waiting for lyr_done, counting toward TIMEOUT
// I_HOLD  | result valid, waiting for res_ready
// T_LOAD  | w_ready high, waiting for a weight row
// T_PULSE | lyr_train_en high for one cycle
// T_GAP   | lyr_train_en low, bias cleared, advance row
module layer_sequencer
   import nn_ctrl_pkg::*;
#(
   parameter int unsigned ROWS      = 30,
   parameter int unsigned COLUMNS   = 64,
   parameter int unsigned DATAWIDTH = 11,
   parameter int unsigned TIMEOUT   = 64,
   localparam int unsigned OW = out_width(ROWS, DATAWIDTH),
   localparam int unsigned BW = bias_width(ROWS, DATAWIDTH),
   localparam int unsigned WW = COLUMNS * DATAWIDTH,
   localparam int unsigned SW = idx_width(ROWS)
) (
   input  logic          clk,
   input  logic          rst_overall_n,
   input  logic          inf_req,
   output logic          inf_busy,
   output logic          res_valid,
   input  logic          res_ready,
   output logic [OW-1:0] res_data,
   input  logic          trn_req,
   input  logic          w_valid,
   output logic          w_ready,
   input  logic [WW-1:0] w_data,
   input  logic [BW-1:0] b_data,
   output logic          trn_done,
   output logic          timeout_err,
   output logic          lyr_en,
   output logic          lyr_rst_vals,
   output logic          lyr_rst_overall,
   output logic          lyr_train_en,
   output logic [SW-1:0] lyr_row_sel,
   output logic [WW-1:0] lyr_weight,
   output logic [BW-1:0] lyr_bias,
   input  logic          lyr_done,
   input  logic [OW-1:0] lyr_out
);

   localparam int unsigned CW = idx_width(TIMEOUT);

   seq_state_t    state_q, state_d;
   logic [CW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic [SW-1:0] row_q, row_d;

   logic          inf_busy_q, inf_busy_d;
   logic          res_valid_q, res_valid_d;
   logic [OW-1:0] res_data_q, res_data_d;
   logic          w_ready_q, w_ready_d;
   logic          trn_done_q, trn_done_d;
   logic          timeout_err_q, timeout_err_d;
   logic          lyr_en_q, lyr_en_d;
   logic          lyr_rst_vals_q, lyr_rst_vals_d;
   logic          lyr_rst_overall_q;
   logic          lyr_train_en_q, lyr_train_en_d;
   logic [SW-1:0] row_sel_q, row_sel_d;
   logic [WW-1:0] weight_q, weight_d;
   logic [BW-1:0] bias_q, bias_d;

   logic accept;
   logic last_row;
   logic timed_out;

   assign accept    = (state_q == T_LOAD) && w_valid;
   assign last_row  = (row_q == SW'(ROWS - 1));
   // done in the same cycle as the limit takes priority over the timeout
   assign timed_out = (state_q == I_WAIT) && !lyr_done && (tmo_cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (!rst_overall_n) begin
         state_q           <= IDLE;
         tmo_cnt_q         <= '0;
         row_q             <= '0;
         inf_busy_q        <= 1'b0;
         res_valid_q       <= 1'b0;
         res_data_q        <= '0;
         w_ready_q         <= 1'b0;
         trn_done_q        <= 1'b0;
         timeout_err_q     <= 1'b0;
         lyr_en_q          <= 1'b0;
         lyr_rst_vals_q    <= 1'b0;
         lyr_rst_overall_q <= 1'b1;
         lyr_train_en_q    <= 1'b0;
         row_sel_q         <= '0;
         weight_q          <= '0;
         bias_q            <= '0;
      end else begin
         state_q           <= state_d;
         tmo_cnt_q         <= tmo_cnt_d;
         row_q             <= row_d;
         inf_busy_q        <= inf_busy_d;
         res_valid_q       <= res_valid_d;
         res_data_q        <= res_data_d;
         w_ready_q         <= w_ready_d;
         trn_done_q        <= trn_done_d;
         timeout_err_q     <= timeout_err_d;
         lyr_en_q          <= lyr_en_d;
         lyr_rst_vals_q    <= lyr_rst_vals_d;
         lyr_rst_overall_q <= 1'b0;
         lyr_train_en_q    <= lyr_train_en_d;
         row_sel_q         <= row_sel_d;
         weight_q          <= weight_d;
         bias_q            <= bias_d;
      end
   end

   // The timeout count measures cycles since the lyr_en cycle: it is 0 while
   // en is high and advances from there, so the limit is hit TIMEOUT cycles
   // after en rose.
   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      row_d     = row_q;
      unique case (state_q)
         IDLE: begin
            if (inf_req)      state_d = I_CLR;
            else if (trn_req) state_d = T_LOAD;
         end
         I_CLR: begin
            state_d   = I_FIRE;
            tmo_cnt_d = '0;
         end
         I_FIRE: begin
            state_d   = I_WAIT;
            tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
         I_WAIT: begin
            if (lyr_done)       state_d = I_HOLD;
            else if (timed_out) state_d = IDLE;
            else                tmo_cnt_d = tmo_cnt_q + 1'b1;
         end
         I_HOLD: begin
            if (res_ready) state_d = IDLE;
         end
         T_LOAD: begin
            if (accept) state_d = T_PULSE;
         end
         T_PULSE: state_d = T_GAP;
         T_GAP: begin
            if (last_row) begin
               row_d   = '0;
               state_d = IDLE;
            end else begin
               row_d   = row_q + 1'b1;
               state_d = T_LOAD;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state and registered, so each level
   // output is high exactly while the FSM sits in the matching state.
   always_comb begin
      inf_busy_d     = state_d inside {I_CLR, I_FIRE, I_WAIT, I_HOLD};
      res_valid_d    = (state_d == I_HOLD);
      w_ready_d      = (state_d == T_LOAD);
      lyr_en_d       = (state_d == I_FIRE);
      lyr_rst_vals_d = (state_d == I_CLR);
      lyr_train_en_d = (state_d == T_PULSE);
      trn_done_d     = (state_q == T_GAP) && last_row;
      timeout_err_d  = timeout_err_q | timed_out;

      res_data_d = res_data_q;
      if ((state_q == I_WAIT) && lyr_done) res_data_d = lyr_out;

      row_sel_d = row_sel_q;
      weight_d  = weight_q;
      bias_d    = bias_q;
      if (accept) begin
         row_sel_d = row_q;
         weight_d  = w_data;
         bias_d    = (row_q == '0) ? b_data : '0;
      end
      // the layer adds bias on every train_en rising edge; clear it for the gap
      if (state_q == T_PULSE) bias_d = '0;
   end

   assign inf_busy        = inf_busy_q;
   assign res_valid       = res_valid_q;
   assign res_data        = res_data_q;
   assign w_ready         = w_ready_q;
   assign trn_done        = trn_done_q;
   assign timeout_err     = timeout_err_q;
   assign lyr_en          = lyr_en_q;
   assign lyr_rst_vals    = lyr_rst_vals_q;
   assign lyr_rst_overall = lyr_rst_overall_q;
   assign lyr_train_en    = lyr_train_en_q;
   assign lyr_row_sel     = row_sel_q;
   assign lyr_weight      = weight_q;
   assign lyr_bias        = bias_q;

endmodule

// File: tb/tb_layer_sequencer.sv
module tb_layer_sequencer;

   localparam int ROWS = 4, COLUMNS = 4, DW = 11, TIMEOUT = 8;
   localparam int OW = ROWS * 2 * DW, WW = COLUMNS * DW, SW = 2;

   logic          clk = 1'b0;
   logic          rst_overall_n, inf_req, res_ready, trn_req, w_valid, lyr_done;
   logic          inf_busy, res_valid, w_ready, trn_done, timeout_err;
   logic          lyr_en, lyr_rst_vals, lyr_rst_overall, lyr_train_en;
   logic [OW-1:0] res_data, b_data, lyr_bias, lyr_out;
   logic [WW-1:0] w_data, lyr_weight;
   logic [SW-1:0] lyr_row_sel;

   always #5 clk = ~clk;

   layer_sequencer #(.ROWS(ROWS), .COLUMNS(COLUMNS), .DATAWIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst_overall_n(rst_overall_n), .inf_req(inf_req), .inf_busy(inf_busy),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .trn_req(trn_req),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .b_data(b_data),
      .trn_done(trn_done), .timeout_err(timeout_err), .lyr_en(lyr_en),
      .lyr_rst_vals(lyr_rst_vals), .lyr_rst_overall(lyr_rst_overall),
      .lyr_train_en(lyr_train_en), .lyr_row_sel(lyr_row_sel), .lyr_weight(lyr_weight),
      .lyr_bias(lyr_bias), .lyr_done(lyr_done), .lyr_out(lyr_out));

   int n_pass = 0, n_total = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // layer model and scoreboard state
   int            done_delay = 3;      // 0: layer never reports done
   bit            rand_delay = 1'b0;
   int            lyr_cnt = 0;
   logic [OW-1:0] next_out = '0;
   logic [OW-1:0] resq[$];
   logic [WW-1:0] wq[$];
   logic [OW-1:0] cur_b = '0, held = '0, last_row0_bias = '0;
   int            acc_row = 0, exp_row = 0, since_last = -1;
   int            en_cnt = 0, res_cnt = 0, pulse_cnt = 0, done_cnt = 0;
   bit            prev_ten = 0, prev_rv = 0, prev_rvals = 0;

   task automatic layer_model();
      lyr_done = 1'b0;
      if (lyr_cnt > 0) begin
         lyr_cnt--;
         if (lyr_cnt == 0) begin
            lyr_done = 1'b1;
            lyr_out  = next_out;
            resq.push_back(next_out);
         end
      end
      if (lyr_en) begin
         if (rand_delay) begin
            lyr_cnt  = $urandom_range(1, TIMEOUT - 1);
            next_out = OW'({$urandom, $urandom, $urandom});
         end else lyr_cnt = done_delay;
      end
   endtask

   task automatic monitor();
      logic [WW-1:0] w_exp;
      if (lyr_en) begin
         en_cnt++;
         chk("rst_vals_before_en", prev_rvals, 1);
      end
      if (res_valid && !prev_rv) begin
         res_cnt++;
         held = (resq.size() > 0) ? resq.pop_front() : 'x;
      end
      if (res_valid) chk("res_data", res_data, held);
      if (since_last >= 0) since_last++;
      if (lyr_train_en) begin
         pulse_cnt++;
         w_exp = (wq.size() > 0) ? wq.pop_front() : 'x;
         chk("train_en_gap", prev_ten, 0);
         chk("row_sel", lyr_row_sel, exp_row);
         chk("weight", lyr_weight, w_exp);
         chk("bias_pulse", lyr_bias, (exp_row == 0) ? cur_b : '0);
         if (exp_row == 0) last_row0_bias = lyr_bias;
         if (exp_row == ROWS - 1) since_last = 0;
         exp_row = (exp_row + 1) % ROWS;
      end else chk("bias_idle", lyr_bias, 0);
      if (trn_done) begin
         done_cnt++;
         chk("trn_done_timing", since_last, 2);
         since_last = -1;
      end else if (since_last > 2) begin
         chk("trn_done_seen", since_last, 2);
         since_last = -1;
      end
      prev_ten   = lyr_train_en;
      prev_rv    = res_valid;
      prev_rvals = lyr_rst_vals;
   endtask

   task automatic step();
      if (w_valid && w_ready) begin
         wq.push_back(w_data);
         if (acc_row == 0) cur_b = b_data;
         acc_row = (acc_row + 1) % ROWS;
      end
      @(posedge clk);
      #1;
      layer_model();
      monitor();
   endtask

   task automatic do_reset(input int n);
      rst_overall_n = 1'b0;
      inf_req = 0; trn_req = 0; w_valid = 0; res_ready = 0;
      wq.delete(); resq.delete();
      acc_row = 0; exp_row = 0; since_last = -1; lyr_cnt = 0; lyr_done = 0;
      repeat (n) step();
      chk("reset_ctrl", {inf_busy, res_valid, w_ready, trn_done, timeout_err, lyr_en,
                         lyr_rst_vals, lyr_rst_overall, lyr_train_en}, 9'b000000010);
      chk("reset_res_data", res_data, 0);
      chk("reset_weight", lyr_weight, 0);
      chk("reset_row_sel", lyr_row_sel, 0);
      rst_overall_n = 1'b1;
      step();
      chk("rst_release", lyr_rst_overall, 0);
   endtask

   task automatic pump_training(input int stall_row, output int stalls);
      int d0;
      d0 = done_cnt;
      stalls = 0;
      for (int i = 0; i < 80 && done_cnt == d0; i++) begin
         w_data = WW'({$urandom, $urandom});
         if (w_ready && acc_row == stall_row && stalls < 2) begin
            w_valid = 0;
            stalls++;
         end else w_valid = 1;
         step();
      end
      w_valid = 0;
      chk("trn_done_count", done_cnt - d0, 1);
   endtask

   typedef struct {
      logic       inf;
      logic       rdy;
      logic [3:0] exp;   // {lyr_rst_vals, lyr_en, inf_busy, res_valid}
   } vec_t;
   vec_t t1[9];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int            stalls, p0, d0, e0, r0, k;
      bit            seen, found;
      logic [OW-1:0] saved, b_pat;

      rst_overall_n = 0; inf_req = 0; res_ready = 0; trn_req = 0; w_valid = 0;
      w_data = '0; b_data = '0; lyr_done = 0; lyr_out = '0;

      t1[0] = '{1'b1, 1'b0, 4'b1010};
      t1[1] = '{1'b0, 1'b0, 4'b0110};
      t1[2] = '{1'b0, 1'b0, 4'b0010};
      t1[3] = '{1'b0, 1'b0, 4'b0010};
      t1[4] = '{1'b0, 1'b0, 4'b0010};
      t1[5] = '{1'b0, 1'b0, 4'b0011};
      t1[6] = '{1'b0, 1'b0, 4'b0011};
      t1[7] = '{1'b0, 1'b1, 4'b0000};
      t1[8] = '{1'b0, 1'b0, 4'b0000};

      // basic inference, layer done 3 cycles after en
      do_reset(3);
      done_delay = 3;
      next_out = '0;
      next_out[21:0] = 22'h000123;
      for (int i = 0; i < 9; i++) begin
         inf_req   = t1[i].inf;
         res_ready = t1[i].rdy;
         step();
         chk($sformatf("t1_row%0d", i), {lyr_rst_vals, lyr_en, inf_busy, res_valid}, t1[i].exp);
         if (i == 5) chk("t1_row0_data", res_data[21:0], 22'h000123);
      end

      // result held while consumer stalls, inf_req ignored in hold
      next_out = OW'({$urandom, $urandom, $urandom});
      inf_req = 1;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin step(); found = res_valid; end
      chk("t2_result", found, 1);
      saved = res_data;
      e0 = en_cnt;
      repeat (10) step();
      chk("t2_hold_data", res_data, saved);
      chk("t2_hold_valid", res_valid, 1);
      chk("t2_no_en", en_cnt - e0, 0);
      res_ready = 1; step(); res_ready = 0;
      chk("t2_taken", res_valid, 0);
      step(); inf_req = 0;
      e0 = en_cnt;
      repeat (20) step();
      chk("t2_one_new_inf", en_cnt - e0, 1);
      chk("t2_second_valid", res_valid, 1);
      res_ready = 1; step(); res_ready = 0;

      // timeout: layer never answers
      do_reset(2);
      done_delay = 0;
      inf_req = 1; step(); inf_req = 0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin step(); found = lyr_en; end
      chk("t3_en_seen", found, 1);
      k = 0; seen = 0;
      for (int i = 0; i < 20 && !timeout_err; i++) begin step(); k++; seen |= res_valid; end
      chk("t3_latency", k, 8);
      chk("t3_idle", {inf_busy, w_ready}, 0);
      repeat (5) begin step(); seen |= res_valid; end
      chk("t3_no_result", seen, 0);
      chk("t3_sticky", timeout_err, 1);
      done_delay = 3;

      // training with a 2-cycle stall before row 2, bias row k = k+1
      do_reset(2);
      b_pat = '0;
      for (int r = 0; r < ROWS; r++) b_pat[r*2*DW +: 2*DW] = 22'(r + 1);
      b_data = b_pat;
      p0 = pulse_cnt;
      trn_req = 1; step(); trn_req = 0;
      pump_training(2, stalls);
      chk("t4_stalls", stalls, 2);
      chk("t4_pulses", pulse_cnt - p0, 4);
      chk("t4_row0_bias", last_row0_bias, b_pat);
      repeat (3) step();

      // tie in IDLE: inference first, training after result taken
      next_out = OW'({$urandom, $urandom, $urandom});
      inf_req = 1; trn_req = 1; step(); inf_req = 0;
      chk("t5_inf_first", {inf_busy, w_ready}, 2'b10);
      found = 0; seen = 0;
      for (int i = 0; i < 20 && !found; i++) begin step(); found = res_valid; seen |= w_ready; end
      chk("t5_result", found, 1);
      chk("t5_no_train_yet", seen, 0);
      res_ready = 1; step(); res_ready = 0;
      step();
      chk("t5_train_start", w_ready, 1);
      trn_req = 0;
      pump_training(ROWS, stalls);

      // reset during the gap after row 1
      do_reset(2);
      trn_req = 1; step(); trn_req = 0;
      found = 0;
      for (int i = 0; i < 30 && !found; i++) begin
         w_valid = 1; w_data = WW'({$urandom, $urandom});
         step();
         found = lyr_train_en && (lyr_row_sel == 2'd1);
      end
      chk("t6_row1_pulse", found, 1);
      w_valid = 0;
      step();
      chk("t6_in_gap", {lyr_train_en, w_ready}, 0);
      do_reset(1);
      b_data = OW'({$urandom, $urandom, $urandom});
      p0 = pulse_cnt;
      trn_req = 1; step(); trn_req = 0;
      pump_training(ROWS, stalls);
      chk("t6_restart_pulses", pulse_cnt - p0, ROWS);

      // randomized traffic against the scoreboard
      do_reset(2);
      rand_delay = 1;
      e0 = en_cnt; r0 = res_cnt; p0 = pulse_cnt; d0 = done_cnt;
      for (int i = 0; i < 800; i++) begin
         inf_req   = ($urandom_range(0, 7) == 0);
         trn_req   = ($urandom_range(0, 9) == 0);
         res_ready = ($urandom_range(0, 2) == 0);
         w_valid   = $urandom_range(0, 1);
         w_data    = WW'({$urandom, $urandom});
         b_data    = OW'({$urandom, $urandom, $urandom});
         step();
      end
      inf_req = 0; trn_req = 0; res_ready = 1; w_valid = 1;
      repeat (60) step();
      w_valid = 0; res_ready = 0;
      chk("rand_inf_results", en_cnt - e0, res_cnt - r0);
      chk("rand_train_rows", pulse_cnt - p0, ROWS * (done_cnt - d0));
      chk("rand_no_timeout", timeout_err, 0);
      chk("rand_idle", {inf_busy, w_ready, res_valid}, 0);
      chk("rand_activity", (en_cnt - e0 > 0) && (done_cnt - d0 > 0), 1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
